// File: rtl/mp64_mem_arbiter_if.sv
// Bus bundle for mp64_mem_arbiter: N requester ports on one side,
// a single mp64_memory CPU-style port on the other, plus status.
// The arbiter connects through the slave modport; the surrounding
// requesters and memory model connect through the master modport.
interface mp64_mem_arbiter_if #(
   parameter int unsigned N_PORTS = 4
);
   // requester side
   logic [N_PORTS-1:0]    m_req;
   logic [N_PORTS*64-1:0] m_addr;
   logic [N_PORTS*64-1:0] m_wdata;
   logic [N_PORTS-1:0]    m_wen;
   logic [N_PORTS*2-1:0]  m_size;
   logic [63:0]           m_rdata;
   logic [N_PORTS-1:0]    m_ack;
   logic                  m_err;
   // memory side
   logic                  mem_req;
   logic [63:0]           mem_addr;
   logic [63:0]           mem_wdata;
   logic                  mem_wen;
   logic [1:0]            mem_size;
   logic [63:0]           mem_rdata;
   logic                  mem_ack;
   // status
   logic [2:0]            grant_id;
   logic                  busy;

   modport slave (
      input  m_req, m_addr, m_wdata, m_wen, m_size, mem_rdata, mem_ack,
      output m_rdata, m_ack, m_err, mem_req, mem_addr, mem_wdata, mem_wen,
             mem_size, grant_id, busy
   );

   modport master (
      output m_req, m_addr, m_wdata, m_wen, m_size, mem_rdata, mem_ack,
      input  m_rdata, m_ack, m_err, mem_req, mem_addr, mem_wdata, mem_wen,
             mem_size, grant_id, busy
   );
endinterface

// File: rtl/mp64_mem_arbiter.sv
// mp64_mem_arbiter: shares one mp64_memory CPU-style port between N_PORTS
// requesters, one transaction at a time, round-robin, with a bus-timeout
// watchdog that completes a stuck access with m_err and all-ones data.
// Build option: define MP64_ARB_PRIO_EN to give port 0 strict priority
// (ports 1..N-1 stay round-robin among themselves; port-0 grants leave
// the round-robin pointer untouched).
module mp64_mem_arbiter #(
   parameter int unsigned N_PORTS     = 4,
   parameter int unsigned TIMEOUT_CYC = 256
) (
   input logic               clk,
   input logic               rst,
   mp64_mem_arbiter_if.slave bus
);
   localparam int unsigned DW    = 64;
   localparam int unsigned SZ_W  = 2;
   localparam int unsigned ID_W  = 3;
   localparam int unsigned VEC_W = 8;
   localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);
   localparam logic [ID_W-1:0]  LAST_RST = ID_W'(N_PORTS - 1);
   localparam bit               WDOG_EN  = (TIMEOUT_CYC != 0);

`ifdef MP64_ARB_PRIO_EN
   localparam bit PRIO_EN = 1'b1;
`else
   localparam bit PRIO_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                state_q, state_n;
   logic [CNT_W-1:0]      cnt_q, cnt_n;
   logic [ID_W-1:0]       last_q, last_n;
   logic [ID_W-1:0]       gid_q, gid_n;
   logic                  mem_req_q, mem_req_n;
   logic [DW-1:0]         mem_addr_q, mem_addr_n;
   logic [DW-1:0]         mem_wdata_q, mem_wdata_n;
   logic                  mem_wen_q, mem_wen_n;
   logic [SZ_W-1:0]       mem_size_q, mem_size_n;
   logic [DW-1:0]         m_rdata_q, m_rdata_n;
   logic [N_PORTS-1:0]    m_ack_q, m_ack_n;
   logic                  m_err_q, m_err_n;
   logic                  busy_q, busy_n;

   logic [VEC_W-1:0]      req_vec;
   logic [VEC_W-1:0]      wen_vec;
   logic [VEC_W-1:0]      ack_vec;
   logic [ID_W-1:0]       scan;
   logic [ID_W-1:0]       sel;
   logic                  sel_vld;
   logic [DW-1:0]         sel_addr;
   logic [DW-1:0]         sel_wdata;
   logic [SZ_W-1:0]       sel_size;
   logic                  sel_wen;

   // Winner search: first requester after the last served port (mod N).
   always_comb begin : pick
      req_vec = VEC_W'(bus.m_req);
      scan    = '0;
      sel     = '0;
      sel_vld = 1'b0;
      for (int unsigned k = 1; k <= N_PORTS; k++) begin
         scan = ID_W'((32'(last_q) + k) % N_PORTS);
         if (!sel_vld && req_vec[scan] && !(PRIO_EN && scan == '0)) begin
            sel     = scan;
            sel_vld = 1'b1;
         end
      end
      if (PRIO_EN && req_vec[0]) begin
         sel     = '0;
         sel_vld = 1'b1;
      end
   end

   // Transaction fields of the selected port.
   always_comb begin : fields
      wen_vec   = VEC_W'(bus.m_wen);
      sel_wen   = wen_vec[sel];
      sel_addr  = '0;
      sel_wdata = '0;
      sel_size  = '0;
      for (int unsigned i = 0; i < N_PORTS; i++) begin
         if (ID_W'(i) == sel) begin
            sel_addr  = bus.m_addr[i*DW +: DW];
            sel_wdata = bus.m_wdata[i*DW +: DW];
            sel_size  = bus.m_size[i*SZ_W +: SZ_W];
         end
      end
   end

   // One-hot completion vector for the owning port.
   always_comb begin : ack_onehot
      ack_vec = VEC_W'(1) << gid_q;
   end

   // Next state and next values of every registered output.
   always_comb begin : fsm_comb
      state_n     = state_q;
      cnt_n       = cnt_q;
      last_n      = last_q;
      gid_n       = gid_q;
      mem_req_n   = mem_req_q;
      mem_addr_n  = mem_addr_q;
      mem_wdata_n = mem_wdata_q;
      mem_wen_n   = mem_wen_q;
      mem_size_n  = mem_size_q;
      m_rdata_n   = m_rdata_q;
      m_ack_n     = '0;
      m_err_n     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (sel_vld) begin
               mem_req_n   = 1'b1;
               mem_addr_n  = sel_addr;
               mem_wdata_n = sel_wdata;
               mem_wen_n   = sel_wen;
               mem_size_n  = sel_size;
               gid_n       = sel;
               cnt_n       = '0;
               state_n     = S_BUSY;
            end
         end
         S_BUSY: begin
            cnt_n = cnt_q + CNT_W'(1);
            // a memory ack beats a watchdog expiry on the same cycle
            if (bus.mem_ack) begin
               mem_req_n = 1'b0;
               m_rdata_n = bus.mem_rdata;
               m_ack_n   = N_PORTS'(ack_vec);
               m_err_n   = 1'b0;
               state_n   = S_DONE;
               if (!(PRIO_EN && gid_q == '0)) last_n = gid_q;
            end else if (WDOG_EN && cnt_q == CNT_LAST) begin
               mem_req_n = 1'b0;
               m_rdata_n = '1;
               m_ack_n   = N_PORTS'(ack_vec);
               m_err_n   = 1'b1;
               state_n   = S_DONE;
               if (!(PRIO_EN && gid_q == '0)) last_n = gid_q;
            end
         end
         S_DONE: begin
            // requests are not sampled here so the served master can drop m_req
            state_n = S_IDLE;
         end
         default: begin
            state_n   = S_IDLE;
            mem_req_n = 1'b0;
         end
      endcase

      busy_n = (state_n != S_IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         last_q      <= LAST_RST;
         gid_q       <= '0;
         mem_req_q   <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_wen_q   <= 1'b0;
         mem_size_q  <= '0;
         m_rdata_q   <= '0;
         m_ack_q     <= '0;
         m_err_q     <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_n;
         cnt_q       <= cnt_n;
         last_q      <= last_n;
         gid_q       <= gid_n;
         mem_req_q   <= mem_req_n;
         mem_addr_q  <= mem_addr_n;
         mem_wdata_q <= mem_wdata_n;
         mem_wen_q   <= mem_wen_n;
         mem_size_q  <= mem_size_n;
         m_rdata_q   <= m_rdata_n;
         m_ack_q     <= m_ack_n;
         m_err_q     <= m_err_n;
         busy_q      <= busy_n;
      end
   end

   assign bus.mem_req   = mem_req_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.mem_wen   = mem_wen_q;
   assign bus.mem_size  = mem_size_q;
   assign bus.m_rdata   = m_rdata_q;
   assign bus.m_ack     = m_ack_q;
   assign bus.m_err     = m_err_q;
   assign bus.grant_id  = gid_q;
   assign bus.busy      = busy_q;

endmodule
